// File: rtl/dijkstra_pkg.sv
// dijkstra_pkg: shared widths, record-field helpers and fetcher states for the node fetcher
package dijkstra_pkg;
    localparam int FIELD_W_DEF = 16;
    localparam int NULL_ID_DEF = 0;
    localparam int MAX_REC_W = 1024;
    typedef enum logic [2:0] {IDLE, SCAN_P, EMIT_P, NEXT_C, SCAN_C, EMIT_C, FIN} state_t;
    function automatic int rec_width(input int max_children, input int field_w);
        return (5 + 2 * max_children) * field_w;
    endfunction
    function automatic logic [63:0] get_field(input logic [MAX_REC_W-1:0] rec, input int lsb, input int field_w);
        return 64'(rec >> lsb) & ((64'd1 << field_w) - 64'd1);
    endfunction
    // Fields are packed MSB first: x, y, node_id, parent, cost, then (child_id, distance) per slot
    function automatic logic [63:0] get_node_id(input logic [MAX_REC_W-1:0] rec, input int rec_w, input int field_w);
        return get_field(rec, rec_w - 3 * field_w, field_w);
    endfunction
    function automatic logic [63:0] get_child_id(input logic [MAX_REC_W-1:0] rec, input int slot, input int rec_w,
                                                 input int field_w);
        return get_field(rec, rec_w - (6 + 2 * slot) * field_w, field_w);
    endfunction
endpackage

// File: rtl/node_id_scanner.sv
// node_id_scanner: pipelined id search over the node memory; DIRECT_INDEX_EN swaps the sweep for one direct read
module node_id_scanner
    import dijkstra_pkg::*;
#(
    parameter int FIELD_W = FIELD_W_DEF,
    parameter int ADDR_W = 7,
    parameter int DEPTH = 128,
    parameter int REC_W = rec_width(6, FIELD_W_DEF)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               run,
    input  logic [FIELD_W-1:0] key,
    input  logic [REC_W-1:0]   mem_node,
    output logic [ADDR_W-1:0]  read_address,
    output logic               hit,
    output logic               miss
);
    logic [ADDR_W-1:0] addr;
    logic vld;
    logic eq;
    assign eq = run && vld && FIELD_W'(get_node_id(MAX_REC_W'(mem_node), REC_W, FIELD_W)) == key;
    assign read_address = addr;
`ifdef DIRECT_INDEX_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            addr <= '0;
            vld <= 1'b0;
        end else if (start) begin
            addr <= key[ADDR_W-1:0];
            vld <= 1'b0;
        end else if (run) begin
            vld <= 1'b1;
        end
    end
    // Addresses beyond the populated range never count as a hit
    assign hit = eq && 32'(addr) < DEPTH;
    assign miss = run && vld && !hit;
`else
    logic [ADDR_W-1:0] last;
    always_ff @(posedge clk) begin
        if (reset) begin
            addr <= '0;
            last <= '0;
            vld <= 1'b0;
        end else if (start) begin
            addr <= '0;
            vld <= 1'b0;
        end else if (run) begin
            addr <= addr + 1'b1;
            last <= addr;
            vld <= 1'b1;
        end
    end
    assign hit = eq;
    assign miss = run && vld && !eq && last == ADDR_W'(DEPTH - 1);
`endif
endmodule

// File: rtl/dijkstra_node_fetcher.sv
// dijkstra_node_fetcher: fetches a node record then each non-null child record and streams them out
// Define DIRECT_INDEX_EN to look records up by direct addressing instead of a linear scan.
module dijkstra_node_fetcher
    import dijkstra_pkg::*;
#(
    parameter int FIELD_W = FIELD_W_DEF,
    parameter int MAX_CHILDREN = 6,
    parameter int ADDR_W = 7,
    parameter int DEPTH = 128,
    parameter int NULL_ID = NULL_ID_DEF,
    localparam int REC_W = rec_width(MAX_CHILDREN, FIELD_W),
    localparam int CW = $clog2(MAX_CHILDREN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               find_node,
    input  logic [FIELD_W-1:0] node_id,
    output logic               busy,
    output logic [ADDR_W-1:0]  read_address,
    input  logic [REC_W-1:0]   mem_node,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [REC_W-1:0]   out_record,
    output logic               out_is_parent,
    output logic [CW-1:0]      out_child_idx,
    output logic               done,
    output logic               found,
    output logic               child_missing
);
    localparam int SW = $clog2(MAX_CHILDREN + 1);
    localparam logic [FIELD_W-1:0] NULL_V = FIELD_W'(NULL_ID);
    state_t state, state_n;
    logic [FIELD_W-1:0] node_q, key;
    logic [MAX_CHILDREN-1:0][FIELD_W-1:0] kids_q, kids_d;
    logic [SW-1:0] slot_q, nxt;
    logic [REC_W-1:0] rec_q;
    logic have, hit, miss, start, run, hs;
    assign hs = out_valid && out_ready;
    assign run = state == SCAN_P || state == SCAN_C;
    assign start = (state == IDLE && find_node) || (state == NEXT_C && have);
    // The key is presented one cycle early so the direct-index variant can load its address on start
    assign key = state == IDLE ? node_id : state == SCAN_P ? node_q : state == NEXT_C ? kids_q[nxt] : kids_q[slot_q];
    assign out_record = rec_q;
    node_id_scanner #(
        .FIELD_W(FIELD_W),
        .ADDR_W(ADDR_W),
        .DEPTH(DEPTH),
        .REC_W(REC_W)
    ) u_scan (
        .clk(clk),
        .reset(reset),
        .start(start),
        .run(run),
        .key(key),
        .mem_node(mem_node),
        .read_address(read_address),
        .hit(hit),
        .miss(miss)
    );
    always_comb begin
        kids_d = '0;
        for (int i = 0; i < MAX_CHILDREN; i++)
            kids_d[i] = FIELD_W'(get_child_id(MAX_REC_W'(mem_node), i, REC_W, FIELD_W));
    end
    // Lowest non-null slot at or after the current one; null slots are skipped
    always_comb begin
        nxt = '0;
        have = 1'b0;
        for (int i = MAX_CHILDREN - 1; i >= 0; i--)
            if (SW'(i) >= slot_q && kids_q[i] != NULL_V) begin
                nxt = SW'(i);
                have = 1'b1;
            end
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        state_n = state;
        busy = state != IDLE && state != FIN;
        out_valid = state == EMIT_P || state == EMIT_C;
        out_is_parent = state == EMIT_P;
        out_child_idx = state == EMIT_C ? CW'(slot_q) : '0;
        done = state == FIN;
        case (state)
            IDLE:    state_n = find_node ? SCAN_P : IDLE;
            SCAN_P:  state_n = hit ? EMIT_P : miss ? FIN : SCAN_P;
            EMIT_P:  state_n = hs ? NEXT_C : EMIT_P;
            NEXT_C:  state_n = have ? SCAN_C : FIN;
            SCAN_C:  state_n = hit ? EMIT_C : miss ? NEXT_C : SCAN_C;
            EMIT_C:  state_n = hs ? NEXT_C : EMIT_C;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            node_q <= '0;
            kids_q <= '0;
            slot_q <= '0;
            rec_q <= '0;
            found <= 1'b0;
            child_missing <= 1'b0;
        end else begin
            case (state)
                IDLE: if (find_node) begin
                    node_q <= node_id;
                    found <= 1'b0;
                    child_missing <= 1'b0;
                end
                SCAN_P: if (hit) begin
                    rec_q <= mem_node;
                    kids_q <= kids_d;
                    found <= 1'b1;
                end
                EMIT_P: if (hs) slot_q <= '0;
                NEXT_C: if (have) slot_q <= nxt;
                SCAN_C: if (hit) begin
                    rec_q <= mem_node;
                end else if (miss) begin
                    child_missing <= 1'b1;
                    slot_q <= slot_q + 1'b1;
                end
                EMIT_C: if (hs) slot_q <= slot_q + 1'b1;
                default: ;
            endcase
        end
    end
endmodule
